// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundle of the requester-side and FIFO-side signals of the write arbiter.
//   req       per-requester write request (word valid while high)
//   req_data  flattened requester words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   full      FIFO full flag
//   gnt       one-hot current owner
//   ack       one-hot, high in the cycle the owner's word is written
//   w_en      FIFO write enable
//   data_in   FIFO write data
//   busy      a grant is active
//   wr_count  total words written, wraps at 2^16
// modport master: the arbiter itself. modport slave: requesters plus FIFO.
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic                          full;
   logic [NUM_REQ-1:0]            gnt;
   logic [NUM_REQ-1:0]            ack;
   logic                          w_en;
   logic [DATA_WIDTH-1:0]         data_in;
   logic                          busy;
   logic [15:0]                   wr_count;

   modport master (
      input  req, req_data, full,
      output gnt, ack, w_en, data_in, busy, wr_count
   );

   modport slave (
      output req, req_data, full,
      input  gnt, ack, w_en, data_in, busy, wr_count
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares the single write port of the async FIFO among NUM_REQ requesters in
// the write clock domain. Round-robin, one burst of up to MAX_BURST words per
// grant; the FIFO full flag stalls a burst without ever releasing it.
// Ports:
//   wclk    write-domain clock
//   wrst_n  asynchronous active-low reset
//   bus     fifo_wr_arbiter_if.master (req/req_data/full in,
//           gnt/ack/w_en/data_in/busy/wr_count out)
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic              wclk,
   input  logic              wrst_n,
   fifo_wr_arbiter_if.master bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST) + 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
   logic [15:0]         wr_count_q;

   logic                wr_fire;
   logic [NUM_REQ-1:0]  owner_mask;
   logic [IDX_W:0]      pick;
   logic                release_burst;
   logic                release_drop;
   logic [NUM_REQ-1:0]  gnt_c;
   logic [NUM_REQ-1:0]  ack_c;
   logic [DATA_WIDTH-1:0] data_c;

   // Round-robin pick: first set bit at index >= start, else the lowest set
   // bit (wrap-around). Result is {found, index}.
   function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input int start);
      logic [IDX_W:0] hi;
      logic [IDX_W:0] lo;
      hi = '0;
      lo = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (r[i]) begin
            lo = {1'b1, IDX_W'(i)};
            if (i >= start) hi = {1'b1, IDX_W'(i)};
         end
      end
      return hi[IDX_W] ? hi : lo;
   endfunction

   assign owner_mask = NUM_REQ'(1) << owner_q;

   // State register
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         last_q      <= LAST_IDX;
         burst_cnt_q <= '0;
         wr_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         burst_cnt_q <= burst_cnt_d;
         if (wr_fire) wr_count_q <= wr_count_q + 16'd1;
      end
   end

   // Next-state logic
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_d        = last_q;
      burst_cnt_d   = burst_cnt_q;
      pick          = '0;
      release_burst = 1'b0;
      release_drop  = 1'b0;
      case (state_q)
         IDLE: begin
            pick = rr_pick(bus.req, int'(last_q) + 1);
            if (pick[IDX_W]) begin
               state_d     = GRANT;
               owner_d     = pick[IDX_W-1:0];
               burst_cnt_d = '0;
            end
         end
         GRANT: begin
            release_burst = wr_fire && (burst_cnt_q == LAST_BEAT);
            release_drop  = !bus.req[owner_q];
            if (release_burst || release_drop) begin
               last_d      = owner_q;
               burst_cnt_d = '0;
               // Outgoing owner is excluded so others get their turn first.
               pick = rr_pick(bus.req & ~owner_mask, int'(owner_q) + 1);
               if (pick[IDX_W]) begin
                  owner_d = pick[IDX_W-1:0];
               end else if (release_burst) begin
                  // Sole remaining requester after a full burst: re-grant it
                  // without a bubble.
                  owner_d = owner_q;
               end else begin
                  state_d = IDLE;
               end
            end else if (wr_fire) begin
               burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      gnt_c   = '0;
      ack_c   = '0;
      data_c  = '0;
      wr_fire = 1'b0;
      if (state_q == GRANT) begin
         gnt_c   = owner_mask;
         wr_fire = bus.req[owner_q] && !bus.full;
         ack_c   = wr_fire ? owner_mask : '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) data_c = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign bus.gnt      = gnt_c;
   assign bus.ack      = ack_c;
   assign bus.w_en     = wr_fire;
   assign bus.data_in  = data_c;
   assign bus.busy     = (state_q == GRANT);
   assign bus.wr_count = wr_count_q;

endmodule
